// File: rtl/oldland_bus_arbiter.sv
// oldland_bus_arbiter: round-robin I/D bus arbiter; OLDLAND_BUS_TIMEOUT_EN adds slave-response timeout
module oldland_bus_arbiter #(
  parameter int timeout_cycles = 256,
  parameter int timeout_bits = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  localparam bit unused_timeout_ok = 2 ** timeout_bits > timeout_cycles;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0] bytesel_q, bytesel_d;
  logic wr_en_q, wr_en_d;
  logic [31:0] wr_val_q, wr_val_d;
  logic busy, load, grant_i, grant_d, timeout, err, ack, done;
`ifdef OLDLAND_BUS_TIMEOUT_EN
  logic [timeout_bits-1:0] cnt_q, cnt_d;
  assign timeout = busy && !m_ack && !m_error && cnt_q == timeout_bits'(timeout_cycles - 1);
  always_comb cnt_d = busy ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign timeout = 1'b0;
`endif
  assign busy = state_q != IDLE;
  assign err = busy && (m_error || timeout);
  assign ack = busy && m_ack && !m_error;
  assign done = ack || err;
  assign grant_i = i_access && (!d_access || last_d_q);
  assign grant_d = d_access && !grant_i;
  assign load = !busy && (grant_i || grant_d);
  assign m_access = busy;
  assign m_addr = addr_q;
  assign m_bytesel = bytesel_q;
  assign m_wr_en = wr_en_q;
  assign m_wr_val = wr_val_q;
  assign i_ack = state_q == I_BUSY && ack;
  assign i_error = state_q == I_BUSY && err;
  assign i_data = state_q == I_BUSY ? m_data : '0;
  assign d_ack = state_q == D_BUSY && ack;
  assign d_error = state_q == D_BUSY && err;
  assign d_data = state_q == D_BUSY ? m_data : '0;
  always_comb begin
    state_d = busy ? (done ? IDLE : state_q) : grant_i ? I_BUSY : grant_d ? D_BUSY : IDLE;
    last_d_d = load ? grant_d : last_d_q;
    addr_d = !load ? addr_q : grant_i ? i_addr : d_addr;
    bytesel_d = !load ? bytesel_q : grant_i ? 4'hf : d_bytesel;
    wr_en_d = !load ? wr_en_q : !grant_i && d_wr_en;
    wr_val_d = !load ? wr_val_q : grant_i ? '0 : d_wr_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_d_q <= 1'b1;
      addr_q <= '0;
      bytesel_q <= '0;
      wr_en_q <= 1'b0;
      wr_val_q <= '0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      addr_q <= addr_d;
      bytesel_q <= bytesel_d;
      wr_en_q <= wr_en_d;
      wr_val_q <= wr_val_d;
    end
  end
endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// tb_oldland_bus_arbiter: directed self-checking bench for oldland_bus_arbiter
module tb_oldland_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic i_access, i_ack, i_error, d_access, d_wr_en, d_ack, d_error;
  logic m_access, m_wr_en, m_ack, m_error;
  logic [29:0] i_addr, d_addr, m_addr;
  logic [3:0] d_bytesel, m_bytesel;
  logic [31:0] i_data, d_wr_val, d_data, m_wr_val, m_data;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  oldland_bus_arbiter #(.timeout_cycles(16), .timeout_bits(5)) dut (
    .clk(clk), .rst(rst),
    .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_error(i_error),
    .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
    .d_wr_val(d_wr_val), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
    .m_access(m_access), .m_addr(m_addr), .m_bytesel(m_bytesel), .m_wr_en(m_wr_en),
    .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack), .m_error(m_error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {i_access, d_access, d_wr_en, m_ack, m_error} = '0;
    i_addr = '0;
    d_addr = '0;
    d_bytesel = '0;
    d_wr_val = '0;
    m_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_access", 32'(m_access), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_bytesel", 32'(m_bytesel), 0);
    chk("rst_wr_en", 32'(m_wr_en), 0);
    chk("rst_wr_val", m_wr_val, 0);
    i_access = 1'b1;
    i_addr = 30'h100;
    #1;
    chk("t1_no_early", 32'(m_access), 0);
    step();
    chk("t1_access", 32'(m_access), 1);
    chk("t1_addr", 32'(m_addr), 32'h100);
    chk("t1_bytesel", 32'(m_bytesel), 32'hf);
    chk("t1_wr_en", 32'(m_wr_en), 0);
    step();
    step();
    step();
    m_ack = 1'b1;
    m_data = 32'hdeadbeef;
    #1;
    chk("t1_i_ack", 32'(i_ack), 1);
    chk("t1_i_data", i_data, 32'hdeadbeef);
    chk("t1_d_ack", 32'(d_ack), 0);
    chk("t1_d_data", d_data, 0);
    step();
    m_ack = 1'b0;
    i_access = 1'b0;
    #1;
    chk("t1_drop", 32'(m_access), 0);
    chk("t1_ack_pulse", 32'(i_ack), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_access = 1'b1;
    d_access = 1'b1;
    i_addr = 30'h200;
    d_addr = 30'h300;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", 32'(m_access), 1);
      chk("rr_addr", 32'(m_addr), k % 2 ? 32'h300 : 32'h200);
      step();
      m_ack = 1'b1;
      #1;
      chk("rr_i_ack", 32'(i_ack), k % 2 ? 0 : 1);
      chk("rr_d_ack", 32'(d_ack), k % 2 ? 1 : 0);
      step();
      m_ack = 1'b0;
      #1;
      chk("rr_gap", 32'(m_access), 0);
    end
    i_access = 1'b0;
    d_access = 1'b0;
    step();
    d_access = 1'b1;
    d_addr = 30'h40;
    d_bytesel = 4'b0011;
    d_wr_en = 1'b1;
    d_wr_val = 32'h12345678;
    step();
    chk("st_addr", 32'(m_addr), 32'h40);
    chk("st_bytesel", 32'(m_bytesel), 32'h3);
    chk("st_wr_en", 32'(m_wr_en), 1);
    chk("st_wr_val", m_wr_val, 32'h12345678);
    d_addr = 30'h99;
    d_bytesel = 4'hc;
    d_wr_val = '0;
    step();
    chk("st_hold_addr", 32'(m_addr), 32'h40);
    chk("st_hold_bytesel", 32'(m_bytesel), 32'h3);
    chk("st_hold_val", m_wr_val, 32'h12345678);
    m_ack = 1'b1;
    #1;
    chk("st_d_ack", 32'(d_ack), 1);
    chk("st_i_ack", 32'(i_ack), 0);
    step();
    m_ack = 1'b0;
    d_access = 1'b0;
    d_wr_en = 1'b0;
    #1;
    chk("st_ack_pulse", 32'(d_ack), 0);
    d_access = 1'b1;
    d_addr = 30'h50;
    step();
    chk("ld_access", 32'(m_access), 1);
    chk("ld_wr_en", 32'(m_wr_en), 0);
    m_ack = 1'b1;
    m_error = 1'b1;
    m_data = 32'hcafef00d;
    #1;
    chk("ld_d_error", 32'(d_error), 1);
    chk("ld_d_ack", 32'(d_ack), 0);
    chk("ld_d_data", d_data, 32'hcafef00d);
    step();
    m_ack = 1'b0;
    m_error = 1'b0;
    d_access = 1'b0;
    #1;
    chk("ld_idle", 32'(m_access), 0);
    chk("ld_err_pulse", 32'(d_error), 0);
    m_ack = 1'b1;
    #1;
    chk("stray_d_ack", 32'(d_ack), 0);
    chk("stray_i_ack", 32'(i_ack), 0);
    chk("stray_d_data", d_data, 0);
    step();
    m_ack = 1'b0;
    #1;
    chk("stray_access", 32'(m_access), 0);
    d_access = 1'b1;
    d_addr = 30'h60;
    step();
    chk("rb_access", 32'(m_access), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    d_access = 1'b0;
    m_ack = 1'b1;
    #1;
    chk("rb_access_low", 32'(m_access), 0);
    chk("rb_addr", 32'(m_addr), 0);
    chk("rb_late_ack", 32'(d_ack), 0);
    step();
    m_ack = 1'b0;
    i_access = 1'b1;
    d_access = 1'b1;
    i_addr = 30'h123;
    d_addr = 30'h321;
    step();
    chk("rb_grant_i", 32'(m_addr), 32'h123);
    m_ack = 1'b1;
    #1;
    chk("rb_i_ack", 32'(i_ack), 1);
    step();
    m_ack = 1'b0;
    i_access = 1'b0;
    d_access = 1'b0;
    step();
`ifdef OLDLAND_BUS_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      i_access = 1'b1;
      step();
      for (int c = 1; c < 15; c++) step();
      #1;
      chk("to_early", 32'(i_error), 0);
      step();
      m_ack = r[0];
      #1;
      chk("to_i_error", 32'(i_error), r ? 0 : 1);
      chk("to_i_ack", 32'(i_ack), r ? 1 : 0);
      step();
      m_ack = 1'b0;
      i_access = 1'b0;
      #1;
      chk("to_drop", 32'(m_access), 0);
      step();
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
